// File: rtl/fwperiph_dma_dbg_pkg.sv
// Shared constants for the DMA debug trace: event type codes and entry field widths.
package fwperiph_dma_dbg_pkg;

    localparam logic [1:0] EV_WRITE     = 2'd0;
    localparam logic [1:0] EV_BUSY_RISE = 2'd1;
    localparam logic [1:0] EV_BUSY_FALL = 2'd2;
    localparam logic [1:0] EV_DONE_RISE = 2'd3;

    localparam int TYPE_W = 2;
    localparam int CH_W   = 5;
    localparam int ADR_W  = 32;
    localparam int DAT_W  = 32;

    // Packed entry width {type, ch, ts, adr, dat} for a given timestamp width.
    function automatic int entry_width(input int ts_w);
        return TYPE_W + CH_W + ts_w + ADR_W + DAT_W;
    endfunction

endpackage

// File: rtl/fwperiph_dma_dbg_trace_if.sv
// Trace drain stream: the trace block is the master, the consumer is the slave.
interface fwperiph_dma_dbg_trace_if #(
    parameter int ts_width = 16
);
    import fwperiph_dma_dbg_pkg::*;

    logic                ev_valid;
    logic                ev_ready;
    logic [TYPE_W-1:0]   ev_type;
    logic [CH_W-1:0]     ev_ch;
    logic [ts_width-1:0] ev_ts;
    logic [ADR_W-1:0]    ev_adr;
    logic [DAT_W-1:0]    ev_dat;

    modport master (
        output ev_valid, ev_type, ev_ch, ev_ts, ev_adr, ev_dat,
        input  ev_ready
    );

    modport slave (
        input  ev_valid, ev_type, ev_ch, ev_ts, ev_adr, ev_dat,
        output ev_ready
    );

endinterface

// File: rtl/fwperiph_dma_dbg_fifo.sv
// Show-ahead synchronous FIFO; the head is visible on dout and forced to 0 when empty.
module fwperiph_dma_dbg_fifo #(
    parameter int width = 87,
    parameter int depth = 16
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     clr,
    input  logic [width-1:0]         din,
    output logic [width-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(depth):0]   count
);
    localparam int AW = $clog2(depth);
    localparam int CW = AW + 1;

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [width-1:0] mem_q [depth];
    logic             do_push, do_pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(depth));
    assign count = count_q;
    assign dout  = empty ? '0 : mem_q[rd_ptr_q];

    // Clear wins over everything; a push at full is only taken alongside a pop.
    always_comb begin
        do_pop   = pop & ~empty & ~clr;
        do_push  = push & ~clr & (~full | do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents need no reset because count gates visibility.
    always_ff @(posedge clock) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/fwperiph_dma_dbg_trace.sv
// DMA debug trace: detects register writes and status edges, timestamps them and
// queues one event per cycle into a trace FIFO; extra or overflowing events are counted.
module fwperiph_dma_dbg_trace
    import fwperiph_dma_dbg_pkg::*;
#(
    parameter int depth    = 16,
    parameter int ts_width = 16
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic [31:0]            adr,
    input  logic [31:0]            dat_w,
    input  logic [31:0]            we,
    input  logic [4:0]             ch_sel,
    input  logic                   dma_busy,
    input  logic                   dma_done_all,
    input  logic                   trace_en,
    input  logic                   trace_clr,
    fwperiph_dma_dbg_trace_if.master ev,
    output logic [$clog2(depth):0] count,
    output logic [15:0]            drop_cnt
);
    localparam int EW = entry_width(ts_width);

    logic [ts_width-1:0] ts_q, ts_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [15:0]         drop_q, drop_d;

    logic                ev_wr, ev_br, ev_bf, ev_dr;
    logic [2:0]          n_ev, n_drop;
    logic [16:0]         drop_sum;
    logic                pop_fire, push_ok, fifo_push;
    logic                fifo_full, fifo_empty;
    logic [1:0]          sel_type;
    logic [EW-1:0]       din, dout;

    // Event detection, priority selection, drop accounting and timestamp update.
    always_comb begin
        ev_wr = trace_en & (|we);
        ev_dr = trace_en & dma_done_all & ~done_q;
        ev_bf = trace_en & ~dma_busy & busy_q;
        ev_br = trace_en & dma_busy & ~busy_q;
        n_ev  = 3'(ev_wr) + 3'(ev_dr) + 3'(ev_bf) + 3'(ev_br);

        pop_fire  = ~fifo_empty & ev.ev_ready;
        push_ok   = ~fifo_full | pop_fire;
        fifo_push = (n_ev != 3'd0) & push_ok & ~trace_clr;

        // Every event that did not make it into the FIFO this cycle is a drop.
        n_drop = 3'd0;
        if (n_ev != 3'd0) n_drop = push_ok ? (n_ev - 3'd1) : n_ev;
        drop_sum = {1'b0, drop_q} + 17'(n_drop);

        if (ev_wr)      sel_type = EV_WRITE;
        else if (ev_dr) sel_type = EV_DONE_RISE;
        else if (ev_bf) sel_type = EV_BUSY_FALL;
        else            sel_type = EV_BUSY_RISE;

        din = {sel_type, ch_sel, ts_q,
               ev_wr ? adr : 32'd0,
               ev_wr ? dat_w : 32'd0};

        drop_d = trace_clr ? 16'd0 : (drop_sum[16] ? 16'hFFFF : drop_sum[15:0]);
        ts_d   = trace_clr ? '0 : ts_q + ts_width'(1);
        busy_d = dma_busy;
        done_d = dma_done_all;
    end

    // Timestamp, edge-detect history and drop counter.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ts_q   <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            drop_q <= '0;
        end else begin
            ts_q   <= ts_d;
            busy_q <= busy_d;
            done_q <= done_d;
            drop_q <= drop_d;
        end
    end

    fwperiph_dma_dbg_fifo #(
        .width (EW),
        .depth (depth)
    ) u_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .push    (fifo_push),
        .pop     (pop_fire),
        .clr     (trace_clr),
        .din     (din),
        .dout    (dout),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (count)
    );

    assign ev.ev_valid = ~fifo_empty;
    assign {ev.ev_type, ev.ev_ch, ev.ev_ts, ev.ev_adr, ev.ev_dat} = dout;
    assign drop_cnt = drop_q;

endmodule

// File: tb/tb_fwperiph_dma_dbg_trace.sv
// Scoreboard bench for the DMA debug trace: a per-cycle reference model queues the
// expected entries and the head of the DUT stream is compared against the queue.
module tb_fwperiph_dma_dbg_trace;

    localparam int DEPTH = 16;

    logic        clock;
    logic        reset_n;
    logic [31:0] adr, dat_w, we;
    logic [4:0]  ch_sel;
    logic        dma_busy, dma_done_all, trace_en, trace_clr;
    logic [4:0]  count;
    logic [15:0] drop_cnt;

    fwperiph_dma_dbg_trace_if #(.ts_width(16)) ev_if ();

    fwperiph_dma_dbg_trace #(.depth(DEPTH), .ts_width(16)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .adr          (adr),
        .dat_w        (dat_w),
        .we           (we),
        .ch_sel       (ch_sel),
        .dma_busy     (dma_busy),
        .dma_done_all (dma_done_all),
        .trace_en     (trace_en),
        .trace_clr    (trace_clr),
        .ev           (ev_if),
        .count        (count),
        .drop_cnt     (drop_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic [1:0]  typ;
        logic [4:0]  ch;
        logic [15:0] ts;
        logic [31:0] adr;
        logic [31:0] dat;
    } exp_t;

    exp_t exp_q[$];
    int   m_ts, m_drop, n_cmp, n_err;
    bit   m_busy, m_done;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_ts = 0; m_drop = 0; m_busy = 0; m_done = 0;
    endtask

    // One clock: check the visible state, advance the model with the applied inputs,
    // then let the DUT take the same edge. Called and returns at a negedge.
    task automatic cycle();
        exp_t e;
        int   w, dr, bf, br, n;
        bit   pop;
        chk("valid", ev_if.ev_valid, exp_q.size() != 0);
        chk("count", count, exp_q.size());
        chk("drop", drop_cnt, m_drop);
        if (exp_q.size() != 0) begin
            e = exp_q[0];
            chk("head_type", ev_if.ev_type, e.typ);
            chk("head_ch", ev_if.ev_ch, e.ch);
            chk("head_ts", ev_if.ev_ts, e.ts);
            chk("head_adr", ev_if.ev_adr, e.adr);
            chk("head_dat", ev_if.ev_dat, e.dat);
        end else begin
            chk("idle_tct", {ev_if.ev_type, ev_if.ev_ch, ev_if.ev_ts}, 0);
            chk("idle_ad", {ev_if.ev_adr, ev_if.ev_dat}, 0);
        end
        pop = (exp_q.size() != 0) && ev_if.ev_ready;
        w  = (trace_en && we != 0) ? 1 : 0;
        dr = (trace_en && dma_done_all && !m_done) ? 1 : 0;
        bf = (trace_en && !dma_busy && m_busy) ? 1 : 0;
        br = (trace_en && dma_busy && !m_busy) ? 1 : 0;
        n  = w + dr + bf + br;
        if (trace_clr) begin
            exp_q.delete();
            m_drop = 0;
        end else begin
            if (pop) void'(exp_q.pop_front());
            if (n > 0) begin
                if (exp_q.size() < DEPTH) begin
                    e.typ = (w != 0) ? 2'd0 : (dr != 0) ? 2'd3 : (bf != 0) ? 2'd2 : 2'd1;
                    e.ch  = ch_sel;
                    e.ts  = m_ts[15:0];
                    e.adr = (w != 0) ? adr : 32'd0;
                    e.dat = (w != 0) ? dat_w : 32'd0;
                    exp_q.push_back(e);
                    n--;
                end
                m_drop = (m_drop + n > 65535) ? 65535 : m_drop + n;
            end
        end
        m_ts   = trace_clr ? 0 : ((m_ts + 1) & 16'hFFFF);
        m_busy = dma_busy;
        m_done = dma_done_all;
        @(posedge clock);
        @(negedge clock);
    endtask

    initial begin
        n_cmp = 0; n_err = 0;
        reset_n = 1'b0; adr = '0; dat_w = '0; we = '0; ch_sel = '0;
        dma_busy = 0; dma_done_all = 0; trace_en = 1; trace_clr = 0;
        ev_if.ev_ready = 1'b0;
        model_reset();
        @(negedge clock); @(negedge clock);
        chk("rst_valid", ev_if.ev_valid, 0);
        chk("rst_count", count, 0);
        chk("rst_drop", drop_cnt, 0);
        reset_n = 1'b1;

        // Single write at ts=5.
        repeat (5) cycle();
        ev_if.ev_ready = 1'b1;
        we = 32'h1; adr = 32'h10; dat_w = 32'hCAFE; ch_sel = 5'd3;
        cycle();
        we = '0;
        chk("wr_valid", ev_if.ev_valid, 1);
        chk("wr_type", ev_if.ev_type, 0);
        chk("wr_ch", ev_if.ev_ch, 3);
        chk("wr_ts", ev_if.ev_ts, 5);
        chk("wr_adr", ev_if.ev_adr, 32'h10);
        chk("wr_dat", ev_if.ev_dat, 32'hCAFE);
        cycle();
        chk("wr_gone", ev_if.ev_valid, 0);

        // Busy high for ts 10..19.
        while (m_ts < 10) cycle();
        dma_busy = 1;
        cycle();
        chk("brise_type", ev_if.ev_type, 1);
        chk("brise_ts", ev_if.ev_ts, 10);
        repeat (9) cycle();
        dma_busy = 0;
        cycle();
        chk("bfall_type", ev_if.ev_type, 2);
        chk("bfall_ts", ev_if.ev_ts, 20);
        repeat (2) cycle();

        // Collision: write, busy rise and done rise together.
        we = 32'h8000_0000; adr = 32'h24; dat_w = 32'h55; dma_busy = 1; dma_done_all = 1;
        cycle();
        we = '0;
        chk("coll_type", ev_if.ev_type, 0);
        chk("coll_drop", drop_cnt, 2);
        dma_busy = 0; dma_done_all = 0;
        repeat (4) cycle();

        // Fill past full with the consumer stalled.
        trace_clr = 1;
        cycle();
        trace_clr = 0;
        ev_if.ev_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            we = 32'h4; adr = 32'h100 + i; dat_w = $urandom; ch_sel = 5'(i);
            cycle();
        end
        chk("full_count", count, 16);
        chk("full_drop", drop_cnt, 4);
        ev_if.ev_ready = 1'b1; adr = 32'h200;
        cycle();
        we = '0;
        chk("fullpp_count", count, 16);
        chk("fullpp_drop", drop_cnt, 4);
        repeat (20) cycle();

        // Random traffic with random back-pressure.
        for (int i = 0; i < 300; i++) begin
            we = ($urandom_range(0, 2) == 0) ? $urandom : 32'd0;
            adr = $urandom; dat_w = $urandom; ch_sel = 5'($urandom);
            if ($urandom_range(0, 5) == 0) dma_busy = ~dma_busy;
            if ($urandom_range(0, 7) == 0) dma_done_all = ~dma_done_all;
            trace_en = ($urandom_range(0, 9) != 0);
            ev_if.ev_ready = $urandom_range(0, 1) != 0;
            cycle();
        end
        trace_en = 1; dma_busy = 0; dma_done_all = 0; we = '0;
        ev_if.ev_ready = 1'b1;
        repeat (20) cycle();

        // Clear together with a push and a pop.
        ev_if.ev_ready = 1'b0; we = 32'h2; adr = 32'h40;
        repeat (3) cycle();
        ev_if.ev_ready = 1'b1; trace_clr = 1;
        cycle();
        trace_clr = 0;
        chk("clr_count", count, 0);
        chk("clr_valid", ev_if.ev_valid, 0);
        chk("clr_drop", drop_cnt, 0);
        ev_if.ev_ready = 1'b0;
        cycle();
        we = '0;
        chk("clr_ts", ev_if.ev_ts, 0);
        repeat (4) cycle();

        // Asynchronous reset with entries queued.
        trace_clr = 1;
        cycle();
        trace_clr = 0;
        for (int i = 0; i < 5; i++) begin
            we = 32'h1; adr = 32'h300 + i; dat_w = 32'(i);
            cycle();
        end
        we = '0;
        chk("pre_rst_count", count, 5);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_valid", ev_if.ev_valid, 0);
        chk("arst_count", count, 0);
        model_reset();
        @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1; dma_busy = 1; trace_en = 1;
        cycle();
        chk("rel_type", ev_if.ev_type, 1);
        chk("rel_ts", ev_if.ev_ts, 0);
        ev_if.ev_ready = 1'b1;
        repeat (4) cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
